// File: rtl/lane_share_scheduler.sv
// lane_share_scheduler
//   Round-robin scheduler sharing one processing unit among N_LANES requester
//   lanes. Each operation goes arbitrate (IDLE) -> ISSUE -> WAIT -> DELIVER.
//   Only one operation is outstanding at a time. A watchdog aborts a WAIT that
//   never sees unit_done.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   req_valid     : per-lane request pending, held until that lane's req_ready
//   req_ready     : one-hot acceptance pulse; lane data is consumed this cycle
//   mux_sel       : input mux select (lane routed into the unit)
//   unit_valid    : operand valid towards the shared unit
//   unit_ready    : unit accepts operand when unit_valid & unit_ready
//   unit_done     : one-cycle result pulse from the unit
//   demux_sel     : output demux select (lane receiving the result)
//   resp_valid    : one-hot one-cycle result strobe to the granted lane
//   busy          : high whenever the FSM is not in IDLE
//   err_timeout   : sticky, watchdog abort seen
//   err_spurious  : sticky, unit_done seen outside WAIT
//   dbg_state     : current FSM state encoding (observation only)
//
// Handshake: an operand transfer happens in exactly the cycle where
// unit_valid & unit_ready are both high; req_ready[grant] is raised in that
// same cycle and nowhere else. resp_valid is a strobe with no back-pressure.
module lane_share_scheduler #(
  parameter int N_LANES = 8,
  parameter int TIMEOUT = 256,
  localparam int SEL_W = $clog2(N_LANES),
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] req_valid,
  output logic [N_LANES-1:0] req_ready,
  output logic [SEL_W-1:0]   mux_sel,
  output logic               unit_valid,
  input  logic               unit_ready,
  input  logic               unit_done,
  output logic [SEL_W-1:0]   demux_sel,
  output logic [N_LANES-1:0] resp_valid,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_spurious,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0] demux_sel_q, demux_sel_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             err_to_q, err_to_d;
  logic             err_sp_q, err_sp_d;

  logic             arb_found;
  logic [SEL_W-1:0] arb_lane;

  // Round-robin search starting just after the last served lane. Offset
  // N_LANES wraps to zero, so the last served lane is checked last.
  always_comb begin
    logic [SEL_W-1:0] cand;
    arb_found = 1'b0;
    arb_lane  = last_q;
    cand      = last_q;
    for (int i = 1; i <= N_LANES; i++) begin
      cand = last_q + SEL_W'(i);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_lane  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mux_sel_d   = mux_sel_q;
    demux_sel_d = demux_sel_q;
    wd_d        = wd_q;
    err_to_d    = err_to_q;
    err_sp_d    = err_sp_q;
    req_ready   = '0;
    resp_valid  = '0;
    unit_valid  = 1'b0;

    // A result pulse is only meaningful while an operation is outstanding.
    if (unit_done && (state_q != ST_WAIT)) begin
      err_sp_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d   = arb_lane;
          mux_sel_d = arb_lane;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        unit_valid = 1'b1;
        if (unit_ready) begin
          req_ready[grant_q] = 1'b1;
          last_d             = grant_q;
          wd_d               = '0;
          state_d            = ST_WAIT;
        end else if (!req_valid[grant_q]) begin
          // Requester withdrew before acceptance: drop the slot quietly and
          // leave the round-robin pointer where it was.
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        wd_d = wd_q + CNT_W'(1);
        if (unit_done) begin
          demux_sel_d = grant_q;
          state_d     = ST_DELIVER;
        end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        resp_valid[grant_q] = 1'b1;
        state_d             = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= SEL_W'(N_LANES - 1);
      mux_sel_q   <= '0;
      demux_sel_q <= '0;
      wd_q        <= '0;
      err_to_q    <= 1'b0;
      err_sp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mux_sel_q   <= mux_sel_d;
      demux_sel_q <= demux_sel_d;
      wd_q        <= wd_d;
      err_to_q    <= err_to_d;
      err_sp_q    <= err_sp_d;
    end
  end

  assign mux_sel      = mux_sel_q;
  assign demux_sel    = demux_sel_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_timeout  = err_to_q;
  assign err_spurious = err_sp_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lane_share_scheduler.sv
// Testbench for lane_share_scheduler: directed scenarios followed by a
// randomized traffic phase. Expected grants/results are queued when the
// stimulus is issued and a negedge monitor pops and compares them.
module tb_lane_share_scheduler;

  localparam int N  = 8;
  localparam int TO = 256;
  localparam int SW = 3;
  localparam int RAND_OPS = 60;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [SW-1:0] mux_sel;
  logic          unit_valid;
  logic          unit_ready;
  logic          unit_done;
  logic [SW-1:0] demux_sel;
  logic [N-1:0]  resp_valid;
  logic          busy;
  logic          err_timeout;
  logic          err_spurious;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp_resp_q[$];
  int            hits[N];
  logic [SW-1:0] mon_e;

  lane_share_scheduler #(
    .N_LANES(N),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mux_sel     (mux_sel),
    .unit_valid  (unit_valid),
    .unit_ready  (unit_ready),
    .unit_done   (unit_done),
    .demux_sel   (demux_sel),
    .resp_valid  (resp_valid),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_spurious(err_spurious),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int l);
    logic [N-1:0] v;
    v    = '0;
    v[l] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first requesting lane after 'last', wrapping.
  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int l;
      l = (last + k) % N;
      if (mask[l]) return l;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_accept(output int lane, output bit ok);
    ok   = 1'b0;
    lane = 0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int l = 0; l < N; l++) if (req_ready[l]) lane = l;
      end
    end
    if (ok) hits[lane]++;
    else check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Called right after the accepting negedge: clears requests, then pulses
  // unit_done 'dly' cycles after acceptance. Returns in the DELIVER cycle.
  task automatic finish_op(input logic [N-1:0] clr, input int dly);
    step();
    req_valid = req_valid & ~clr;
    for (int i = 1; i < dly; i++) step();
    unit_done = 1'b1;
    step();
    unit_done = 1'b0;
  endtask

  task automatic serve(input int lane, input int dly, input logic [N-1:0] clr);
    int  got;
    bit  ok;
    exp_q.push_back(SW'(lane));
    exp_resp_q.push_back(SW'(lane));
    wait_accept(got, ok);
    finish_op(clr, dly);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        if (exp_q.size() == 0) begin
          check("grant_unexpected", 32'(req_ready), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_lane", 32'(req_ready), 32'(onehot(int'(mon_e))));
          check("grant_mux_sel", 32'(mux_sel), 32'(mon_e));
        end
      end
      if (resp_valid != '0) begin
        if (exp_resp_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = exp_resp_q.pop_front();
          check("resp_lane", 32'(resp_valid), 32'(onehot(int'(mon_e))));
          check("resp_demux_sel", 32'(demux_sel), 32'(mon_e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int           lane;
    bit           ok;
    logic [N-1:0] clr;
    logic [N-1:0] pending;
    int           m_last, m_next, ops, cyc, done_cnt;
    bit           inflight, acc, got_resp;

    req_valid  = '0;
    unit_ready = 1'b0;
    unit_done  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) step();

    // reset state
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_unit_valid", 32'(unit_valid), 32'd0);
    check("rst_demux_sel", 32'(demux_sel), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_err_spurious", 32'(err_spurious), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // single request on lane 2, done 3 cycles after accept
    req_valid  = 8'h04;
    unit_ready = 1'b1;
    exp_q.push_back(SW'(2));
    exp_resp_q.push_back(SW'(2));
    step();
    @(negedge clk);
    check("t1_mux_sel", 32'(mux_sel), 32'd2);
    check("t1_unit_valid", 32'(unit_valid), 32'd1);
    check("t1_req_ready", 32'(req_ready), 32'h04);
    step();
    req_valid = '0;
    step();
    step();
    unit_done = 1'b1;
    step();
    unit_done = 1'b0;
    @(negedge clk);
    check("t1_resp_valid", 32'(resp_valid), 32'h04);
    check("t1_demux_sel", 32'(demux_sel), 32'd2);
    step();
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_state_idle", 32'(dbg_state), 32'd0);
    step();

    // all lanes held: 16 operations in strict rotation
    do_reset();
    foreach (hits[l]) hits[l] = 0;
    req_valid  = '1;
    unit_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      clr = (k == 15) ? {N{1'b1}} : '0;
      serve(k % N, 1, clr);
    end
    for (int l = 0; l < N; l++) check("t2_pulses_per_lane", 32'(hits[l]), 32'd2);

    // lane 3 served, then lanes 0 and 3 requesting: 0 wins, then 3
    req_valid = 8'h08;
    serve(3, 2, 8'h08);
    req_valid = 8'h09;
    serve(0, 1, 8'h01);
    serve(3, 3, 8'h08);

    // unit stalls 10 cycles in ISSUE on lane 5
    req_valid  = 8'h20;
    unit_ready = 1'b0;
    exp_q.push_back(SW'(5));
    exp_resp_q.push_back(SW'(5));
    ok = 1'b0;
    for (int c = 0; c < 16 && !ok; c++) begin
      @(negedge clk);
      if (unit_valid) ok = 1'b1;
    end
    check("t4_reach_issue", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_unit_valid_held", 32'(unit_valid), 32'd1);
      check("t4_mux_sel_held", 32'(mux_sel), 32'd5);
      check("t4_no_req_ready", 32'(req_ready), 32'd0);
    end
    step();
    unit_ready = 1'b1;
    @(negedge clk);
    check("t4_req_ready", 32'(req_ready), 32'h20);
    finish_op(8'h20, 2);

    // watchdog: unit_done never arrives on lane 1
    req_valid = 8'h02;
    exp_q.push_back(SW'(1));
    wait_accept(lane, ok);
    step();
    req_valid = '0;
    repeat (255) step();
    @(negedge clk);
    check("t5_no_timeout_early", 32'(err_timeout), 32'd0);
    check("t5_busy_in_wait", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    check("t5_err_timeout", 32'(err_timeout), 32'd1);
    check("t5_idle_after_abort", 32'(dbg_state), 32'd0);
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    step();
    unit_done = 1'b1;
    @(negedge clk);
    check("t5_spurious_not_yet", 32'(err_spurious), 32'd0);
    step();
    unit_done = 1'b0;
    @(negedge clk);
    check("t5_err_spurious", 32'(err_spurious), 32'd1);
    check("t5_timeout_sticky", 32'(err_timeout), 32'd1);
    step();

    // reset asserted while waiting for a result on lane 6
    req_valid = 8'h40;
    exp_q.push_back(SW'(6));
    wait_accept(lane, ok);
    step();
    req_valid = '0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_mux_sel", 32'(mux_sel), 32'd0);
    check("t6_unit_valid", 32'(unit_valid), 32'd0);
    check("t6_demux_sel", 32'(demux_sel), 32'd0);
    check("t6_resp_valid", 32'(resp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_err_timeout", 32'(err_timeout), 32'd0);
    check("t6_err_spurious", 32'(err_spurious), 32'd0);
    step();
    unit_done = 1'b1;
    @(negedge clk);
    check("t6_resp_in_reset", 32'(resp_valid), 32'd0);
    step();
    unit_done = 1'b0;
    @(negedge clk);
    check("t6_spurious_in_reset", 32'(err_spurious), 32'd0);
    check("t6_resp_after_done", 32'(resp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("t6_idle_after_release", 32'(busy), 32'd0);
    check("t6_spurious_after_release", 32'(err_spurious), 32'd0);
    step();

    // randomized traffic against the round-robin reference
    do_reset();
    pending  = '0;
    m_last   = N - 1;
    m_next   = 0;
    ops      = 0;
    cyc      = 0;
    done_cnt = 0;
    inflight = 1'b0;
    while (!(ops >= RAND_OPS && pending == '0 && !inflight) && cyc < 5000) begin
      @(negedge clk);
      acc      = (req_ready != '0);
      got_resp = (resp_valid != '0);
      step();
      cyc++;
      if (got_resp) inflight = 1'b0;
      if (acc) begin
        pending[m_next] = 1'b0;
        m_last          = m_next;
        inflight        = 1'b1;
        ops++;
        exp_resp_q.push_back(SW'(m_next));
        done_cnt = $urandom_range(1, 5);
        if (ops < RAND_OPS && $urandom_range(0, 1) == 1)
          pending = pending | N'($urandom_range(1, 255));
        if (pending != '0) begin
          m_next = rr_pick(pending, m_last);
          exp_q.push_back(SW'(m_next));
        end
      end else if (pending == '0 && !inflight && ops < RAND_OPS) begin
        pending = N'($urandom_range(1, 255));
        m_next  = rr_pick(pending, m_last);
        exp_q.push_back(SW'(m_next));
      end
      unit_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) unit_done = 1'b1;
      end
      req_valid  = pending;
      unit_ready = ($urandom_range(0, 3) != 0);
    end
    unit_done = 1'b0;
    req_valid = '0;
    check("rand_ops_completed", 32'(ops >= RAND_OPS && !inflight), 32'd1);
    step();
    step();

    // final report
    check("end_grant_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
    check("end_err_timeout", 32'(err_timeout), 32'd0);
    check("end_err_spurious", 32'(err_spurious), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
